// File: rtl/genc_boot_ctrl.sv
// genc boot/run sequencer: streams a program into instruction memory with the core held in reset,
// then runs it until hata, PC self-loop or watchdog. Define GENC_BOOT_CSUM_EN for a trailing checksum word.
module genc_boot_ctrl #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned STALL_CYC  = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  input  logic [31:0]       core_pc,
  input  logic              core_hata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycles
`ifdef GENC_BOOT_CSUM_EN
  ,
  output logic              csum_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_HALT} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [ADDR_W:0]    r_len, r_idx;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [1:0]         r_status;
  logic [CNT_W-1:0]   r_cycles;
  logic [31:0]        r_prev_pc;
  logic               r_first;
  logic [31:0]        r_stall;

  logic               w_start_ok, w_hs, w_data_hs;
  logic [ADDR_W:0]    w_len;
  logic [CNT_W-1:0]   w_cyc_nxt;
  logic               w_pc_same, w_norm_end, w_to_end;
  logic [31:0]        w_stall_nxt;

  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_HALT));
  assign w_len       = (load_len > DEPTH) ? DEPTH : load_len;
  assign w_hs        = in_valid & (r_state == S_LOAD);
  assign w_data_hs   = w_hs & (r_idx < r_len);
  assign w_cyc_nxt   = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
  // First RUN cycle only primes r_prev_pc, so it can never count as a stall.
  assign w_pc_same   = ~r_first & (core_pc == r_prev_pc);
  assign w_stall_nxt = w_pc_same ? r_stall + 32'd1 : '0;
  assign w_norm_end  = w_pc_same & (w_stall_nxt == 32'(STALL_CYC - 1));
  assign w_to_end    = (w_cyc_nxt >= CNT_W'(MAX_CYCLES));

`ifdef GENC_BOOT_CSUM_EN
  logic [31:0] r_sum;
  logic        r_csum_err;
  logic        w_ck_hs, w_ck_ok;
  assign w_ck_hs  = w_hs & (r_idx == r_len);
  assign w_ck_ok  = (in_data == r_sum);
  assign csum_err = r_csum_err;
`else
  logic w_last;
  assign w_last = w_data_hs & (r_idx == r_len - ONE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start) w_state_nxt = (w_len == '0) ? S_SETTLE : S_LOAD;
      S_LOAD: begin
`ifdef GENC_BOOT_CSUM_EN
        if (w_ck_hs) w_state_nxt = w_ck_ok ? S_SETTLE : S_HALT;
`else
        if (w_last) w_state_nxt = S_SETTLE;
`endif
      end
      S_SETTLE: w_state_nxt = S_RUN;
      S_RUN:    if (core_hata | w_norm_end | w_to_end) w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_status    <= '0;
      r_cycles    <= '0;
      r_prev_pc   <= '0;
      r_first     <= 1'b1;
      r_stall     <= '0;
`ifdef GENC_BOOT_CSUM_EN
      r_sum       <= '0;
      r_csum_err  <= 1'b0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_len    <= w_len;
        r_idx    <= '0;
        r_status <= '0;
        r_cycles <= '0;
`ifdef GENC_BOOT_CSUM_EN
        r_sum      <= '0;
        r_csum_err <= 1'b0;
`endif
      end
      if (w_data_hs) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_idx[ADDR_W-1:0];
        r_mem_wdata <= in_data;
        r_idx       <= r_idx + ONE;
`ifdef GENC_BOOT_CSUM_EN
        r_sum       <= r_sum + in_data;
`endif
      end
`ifdef GENC_BOOT_CSUM_EN
      if (w_ck_hs && !w_ck_ok) r_csum_err <= 1'b1;
`endif
      if (r_state == S_SETTLE) begin
        r_first <= 1'b1;
        r_stall <= '0;
      end
      if (r_state == S_RUN) begin
        r_cycles  <= w_cyc_nxt;
        r_first   <= 1'b0;
        r_prev_pc <= core_pc;
        r_stall   <= w_stall_nxt;
        if (core_hata)       r_status <= 2'b10;
        else if (w_norm_end) r_status <= 2'b01;
        else if (w_to_end)   r_status <= 2'b11;
      end
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign core_hold = (r_state != S_RUN);
  assign busy      = (r_state == S_LOAD) | (r_state == S_SETTLE) | (r_state == S_RUN);
  assign done      = (r_state == S_HALT);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign status    = r_status;
  assign cycles    = r_cycles;

endmodule

// File: doc/genc_boot_ctrl.md
Name: genc_boot_ctrl

Overview:
Boot and run sequencer for the genc single-cycle core.
- Loads a program from a valid/ready word stream into the core's instruction memory while holding the core in reset.
- Releases the core, counts cycles, and stops it on hata, end-of-program (PC self-loop) or watchdog timeout.
- Sits between the host/loader interface and the genc core plus its instruction memory write port.

Parameters:
ADDR_W, 6, instruction memory word-address width (depth 2^ADDR_W words)
MAX_CYCLES, 100000, watchdog limit in RUN cycles
STALL_CYC, 4, consecutive unchanged-PC cycles that mean end of program
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse, begin a session
load_len  in  ADDR_W+1  number of words to load; 0 = rerun existing program
in_valid  in  1  stream word valid
in_data  in  32  stream word
in_ready  out  1  controller accepts word
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  write data
core_hold  out  1  1 = hold core in reset
core_pc  in  32  core program counter
core_hata  in  1  core error flag
busy  out  1  session in LOAD/SETTLE/RUN
done  out  1  session finished (level)
status  out  2  00 none, 01 normal end, 10 hata, 11 timeout
cycles  out  CNT_W  RUN cycles of current/last session

Behaviour:
- Reset values: state IDLE, core_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, status=00, cycles=0.
- Reset mid-operation: any state returns to IDLE immediately (asynchronous); a partially loaded program is left in memory as-is.
- States: IDLE, LOAD, SETTLE, RUN, HALT.
- IDLE
  - start=1: latch len = min(load_len, 2^ADDR_W); clear done, status and cycles; set busy=1.
  - len>0 -> LOAD. len==0 -> SETTLE.
- LOAD
  - in_ready=1 for the whole state; 0 in every other state. Words presented outside LOAD are ignored.
  - Each handshake (in_valid & in_ready) registers mem_we=1, mem_addr=index, mem_wdata=in_data. The write pulse appears the cycle after the handshake; index increments from 0.
  - in_valid gaps are allowed; mem_we=0 on idle cycles.
  - Handshake of word len-1 -> SETTLE.
- SETTLE
  - One cycle. The last write completes here; core_hold stays 1.
  - Clears the PC tracker -> RUN.
- RUN
  - core_hold=0; cycles increments every cycle, saturating at all-ones.
  - The first RUN cycle only samples prev_pc. From then on, core_pc==prev_pc increments stall_cnt; otherwise stall_cnt clears.
  - Exit conditions, evaluated each cycle; on the next edge -> HALT:
    - core_hata=1 -> status 10
    - else stall_cnt reaches STALL_CYC-1 with PC still equal -> status 01
    - else cycles reaches MAX_CYCLES -> status 11
  - Priority when simultaneous: hata > normal end > timeout.
- HALT
  - core_hold=1, busy=0, done=1; status and cycles frozen.
  - start -> same handling as IDLE (new session).
- start is ignored while busy=1.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational paths.

Optional Feature:
GENC_BOOT_CSUM_EN
- Defined:
  - LOAD accepts one extra word after the len data words: the expected checksum, the 32-bit wraparound sum of all data words. It is not written to memory.
  - Added output port csum_err (1 bit, reset 0).
  - Match -> SETTLE.
  - Mismatch -> HALT with csum_err=1, status=00. The core is never released.
  - len==0 skips the checksum word.
  - csum_err clears on the next accepted start.
- Undefined: no csum_err port, no extra word.

Test Plan:
- Load 3 words 0x00000013, 0x00100093, 0x0000006F with continuous in_valid -> mem_we pulses at addr 0,1,2 one cycle after each handshake; in_ready drops after word 3; core_hold=1 through SETTLE, 0 in RUN.
- Same load with in_valid gaps of 2 cycles between words -> identical writes, mem_we=0 during gaps, busy=1 throughout.
- RUN with core_pc stepping 0,4,8 then holding 0x08 (STALL_CYC=4) -> HALT, done=1, status=01, core_hold=1, cycles frozen.
- core_hata=1 for one cycle at RUN cycle 10 while PC also stalls -> status=10 (hata priority), cycles=10 frozen; start during RUN earlier ignored.
- MAX_CYCLES=20, PC incrementing every cycle -> status=11, cycles=20; start in HALT with load_len=0 -> SETTLE, RUN, cycles restarts from 0.
- reset pulsed after 2 of 5 words in LOAD -> all outputs at reset values within the reset cycle; new start reloads from addr 0. With GENC_BOOT_CSUM_EN: words 1,2,3 + checksum 6 -> RUN; checksum 7 -> HALT, csum_err=1, core_hold stays 1.
